// File: rtl/ex_wb_collector.sv
// ex_wb_collector: collects ex_stage results (FLU, load, store, FPU) into per-source FIFOs
// and drains them round-robin onto NR_WB_PORTS registered scoreboard write ports.
// Optional duplicate trans_id checker is built when EX_WB_DUP_CHECK_EN is defined;
// otherwise dup_err_o is tied low and no compare logic exists.
module ex_wb_collector #(
  parameter int unsigned NR_WB_PORTS   = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        flush_i,
  input  logic [3:0]                                  src_valid_i,
  input  logic [3:0][TRANS_ID_BITS-1:0]               src_trans_id_i,
  input  logic [3:0][63:0]                            src_result_i,
  input  logic [3:0]                                  src_ex_valid_i,
  input  logic [3:0][63:0]                            src_ex_cause_i,
  output logic [NR_WB_PORTS-1:0]                      wb_valid_o,
  output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [NR_WB_PORTS-1:0][63:0]                wb_data_o,
  output logic [NR_WB_PORTS-1:0]                      wb_ex_valid_o,
  output logic [NR_WB_PORTS-1:0][63:0]                wb_ex_cause_o,
  output logic                                        issue_stall_o,
  output logic                                        overflow_o,
  output logic                                        dup_err_o
);

  localparam int unsigned NR_SRC = 4;
  localparam int unsigned SRC_W  = 2;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              result;
    logic                     ex_valid;
    logic [63:0]              ex_cause;
  } wb_entry_t;

  wb_entry_t                        mem_q [NR_SRC][FIFO_DEPTH];
  logic [NR_SRC-1:0][PTR_W-1:0]     rd_ptr_q;
  logic [NR_SRC-1:0][PTR_W-1:0]     wr_ptr_q;
  logic [NR_SRC-1:0][CNT_W-1:0]     cnt_q;
  logic [SRC_W-1:0]                 rr_q;
  logic [SRC_W-1:0]                 rr_d;

  logic [NR_SRC-1:0]                pop;
  logic [NR_SRC-1:0]                push_ok;
  logic [NR_SRC-1:0]                drop;
  logic [NR_WB_PORTS-1:0]           port_vld;
  logic [NR_WB_PORTS-1:0][SRC_W-1:0] port_src;
  wb_entry_t                        head [NR_WB_PORTS];

  // Round-robin grant of the first NR_WB_PORTS non-empty FIFOs starting at rr_q
  always_comb begin
    logic [NR_SRC-1:0] avail;
    logic              found;
    logic [SRC_W-1:0]  idx;
    avail    = '0;
    found    = 1'b0;
    idx      = '0;
    pop      = '0;
    port_vld = '0;
    port_src = '0;
    rr_d     = rr_q;
    for (int k = 0; k < NR_SRC; k++) begin
      idx      = rr_q + SRC_W'(k);
      avail[k] = (cnt_q[idx] != '0);
    end
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      found = 1'b0;
      for (int k = 0; k < NR_SRC; k++) begin
        if (!found && avail[k]) begin
          found       = 1'b1;
          avail[k]    = 1'b0;
          idx         = rr_q + SRC_W'(k);
          port_vld[p] = 1'b1;
          port_src[p] = idx;
          pop[idx]    = 1'b1;
          rr_d        = idx + SRC_W'(1);
        end
      end
    end
  end

  // A full FIFO only accepts a push when its head leaves in the same cycle
  always_comb begin
    push_ok = '0;
    drop    = '0;
    for (int s = 0; s < NR_SRC; s++) begin
      if (src_valid_i[s] && !flush_i) begin
        if ((cnt_q[s] != CNT_W'(FIFO_DEPTH)) || pop[s]) push_ok[s] = 1'b1;
        else                                             drop[s]    = 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked by cnt_q
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < NR_SRC; s++) begin
      if (push_ok[s]) begin
        mem_q[s][wr_ptr_q[s]] <= '{trans_id: src_trans_id_i[s],
                                   result:   src_result_i[s],
                                   ex_valid: src_ex_valid_i[s],
                                   ex_cause: src_ex_cause_i[s]};
      end
    end
  end

  // FIFO pointers, counts, arbitration pointer and sticky overflow flag
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      rr_q       <= '0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      rr_q     <= '0;
    end else begin
      for (int s = 0; s < NR_SRC; s++) begin
        if (push_ok[s]) wr_ptr_q[s] <= wr_ptr_q[s] + PTR_W'(1);
        if (pop[s])     rd_ptr_q[s] <= rd_ptr_q[s] + PTR_W'(1);
        cnt_q[s] <= cnt_q[s] + CNT_W'(push_ok[s]) - CNT_W'(pop[s]);
      end
      rr_q <= rr_d;
      if (|drop) overflow_o <= 1'b1;
    end
  end

  // Head entry of the FIFO granted to each port
  always_comb begin
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      head[p] = mem_q[port_src[p]][rd_ptr_q[port_src[p]]];
    end
  end

  // Registered write ports; payload only reloads for granted ports
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_valid_o    <= '0;
      wb_trans_id_o <= '0;
      wb_data_o     <= '0;
      wb_ex_valid_o <= '0;
      wb_ex_cause_o <= '0;
    end else if (flush_i) begin
      wb_valid_o <= '0;
    end else begin
      wb_valid_o <= port_vld;
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (port_vld[p]) begin
          wb_trans_id_o[p] <= head[p].trans_id;
          wb_data_o[p]     <= head[p].result;
          wb_ex_valid_o[p] <= head[p].ex_valid;
          wb_ex_cause_o[p] <= head[p].ex_cause;
        end
      end
    end
  end

  // Stall issue while any FIFO has at most one free slot
  always_comb begin
    issue_stall_o = 1'b0;
    for (int s = 0; s < NR_SRC; s++) begin
      if (cnt_q[s] >= CNT_W'(FIFO_DEPTH - 1)) issue_stall_o = 1'b1;
    end
  end

`ifdef EX_WB_DUP_CHECK_EN
  logic dup_c;

  // Duplicate id across live write ports, or a push matching any occupied FIFO slot
  always_comb begin
    logic [PTR_W-1:0] off;
    dup_c = 1'b0;
    off   = '0;
    for (int a = 0; a < NR_WB_PORTS; a++) begin
      for (int b = a + 1; b < NR_WB_PORTS; b++) begin
        if (wb_valid_o[a] && wb_valid_o[b] && (wb_trans_id_o[a] == wb_trans_id_o[b])) dup_c = 1'b1;
      end
    end
    for (int f = 0; f < NR_SRC; f++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        off = PTR_W'(i) - rd_ptr_q[f];
        for (int s = 0; s < NR_SRC; s++) begin
          if (src_valid_i[s] && (CNT_W'(off) < cnt_q[f]) &&
              (mem_q[f][i].trans_id == src_trans_id_i[s])) dup_c = 1'b1;
        end
      end
    end
  end

  // Sticky duplicate-id flag, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni)    dup_err_o <= 1'b0;
    else if (dup_c) dup_err_o <= 1'b1;
  end
`else
  assign dup_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ex_wb_collector.sv
// Directed self-checking bench for ex_wb_collector (NR_WB_PORTS=2, FIFO_DEPTH=4, TRANS_ID_BITS=3).
module tb_ex_wb_collector;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [3:0]       src_valid;
  logic [3:0][2:0]  src_trans_id;
  logic [3:0][63:0] src_result;
  logic [3:0]       src_ex_valid;
  logic [3:0][63:0] src_ex_cause;
  logic [1:0]       wb_valid;
  logic [1:0][2:0]  wb_trans_id;
  logic [1:0][63:0] wb_data;
  logic [1:0]       wb_ex_valid;
  logic [1:0][63:0] wb_ex_cause;
  logic             issue_stall;
  logic             overflow;
  logic             dup_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] got_seq [$];

  ex_wb_collector #(.NR_WB_PORTS(2), .FIFO_DEPTH(4), .TRANS_ID_BITS(3)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .src_valid_i    (src_valid),
    .src_trans_id_i (src_trans_id),
    .src_result_i   (src_result),
    .src_ex_valid_i (src_ex_valid),
    .src_ex_cause_i (src_ex_cause),
    .wb_valid_o     (wb_valid),
    .wb_trans_id_o  (wb_trans_id),
    .wb_data_o      (wb_data),
    .wb_ex_valid_o  (wb_ex_valid),
    .wb_ex_cause_o  (wb_ex_cause),
    .issue_stall_o  (issue_stall),
    .overflow_o     (overflow),
    .dup_err_o      (dup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    flush        = 1'b0;
    src_valid    = '0;
    src_trans_id = '0;
    src_result   = '0;
    src_ex_valid = '0;
    src_ex_cause = '0;
  endtask

  task automatic drive(input logic [1:0] s, input logic [2:0] id, input logic [63:0] d);
    src_valid[s]    = 1'b1;
    src_trans_id[s] = id;
    src_result[s]   = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n     = 1'b0;
    src_valid = 4'hF;
    for (int s = 0; s < 4; s++) begin
      src_trans_id[s] = 3'(s + 1);
      src_result[s]   = 64'h55 + 64'(s);
    end
    step();
    step();
    n_cmp++; if (wb_valid !== 2'b00) begin n_err++; $display("FAIL reset_valid: got %b expected 00", wb_valid); end
    n_cmp++; if (wb_trans_id !== '0) begin n_err++; $display("FAIL reset_id: got %h expected 0", wb_trans_id); end
    n_cmp++; if (wb_data !== '0) begin n_err++; $display("FAIL reset_data: got %h expected 0", wb_data); end
    n_cmp++; if (wb_ex_valid !== 2'b00 || wb_ex_cause !== '0) begin n_err++; $display("FAIL reset_ex: got %b/%h expected 0", wb_ex_valid, wb_ex_cause); end
    n_cmp++; if ({issue_stall, overflow, dup_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {issue_stall, overflow, dup_err}); end
    idle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (wb_valid !== 2'b00 || issue_stall !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got valid %b stall %b expected 00/0", wb_valid, issue_stall); end
    end
  endtask

  task automatic test_single();
    idle();
    drive(2'd1, 3'd5, 64'hDEAD);
    step();
    idle();
    n_cmp++; if (wb_valid !== 2'b00) begin n_err++; $display("FAIL single_c1: got %b expected 00", wb_valid); end
    step();
    n_cmp++; if (wb_valid !== 2'b01) begin n_err++; $display("FAIL single_valid: got %b expected 01", wb_valid); end
    n_cmp++; if (wb_trans_id[0] !== 3'd5) begin n_err++; $display("FAIL single_id: got %0d expected 5", wb_trans_id[0]); end
    n_cmp++; if (wb_data[0] !== 64'hDEAD) begin n_err++; $display("FAIL single_data: got %h expected dead", wb_data[0]); end
    n_cmp++; if (wb_ex_valid[0] !== 1'b0) begin n_err++; $display("FAIL single_ex: got %b expected 0", wb_ex_valid[0]); end
    step();
    n_cmp++; if (wb_valid !== 2'b00) begin n_err++; $display("FAIL single_c3: got %b expected 00", wb_valid); end
  endtask

  task automatic test_all_sources();
    idle();
    flush = 1'b1;
    step();
    idle();
    for (int s = 0; s < 4; s++) drive(2'(s), 3'(s), 64'h100 + 64'(s));
    src_ex_valid[3] = 1'b1;
    src_ex_cause[3] = 64'hBAD;
    step();
    idle();
    step();
    n_cmp++; if (wb_valid !== 2'b11) begin n_err++; $display("FAIL all_c2_valid: got %b expected 11", wb_valid); end
    n_cmp++; if (wb_trans_id[0] !== 3'd0 || wb_trans_id[1] !== 3'd1) begin n_err++; $display("FAIL all_c2_ids: got %0d,%0d expected 0,1", wb_trans_id[0], wb_trans_id[1]); end
    n_cmp++; if (wb_data[0] !== 64'h100 || wb_data[1] !== 64'h101) begin n_err++; $display("FAIL all_c2_data: got %h,%h expected 100,101", wb_data[0], wb_data[1]); end
    step();
    n_cmp++; if (wb_valid !== 2'b11) begin n_err++; $display("FAIL all_c3_valid: got %b expected 11", wb_valid); end
    n_cmp++; if (wb_trans_id[0] !== 3'd2 || wb_trans_id[1] !== 3'd3) begin n_err++; $display("FAIL all_c3_ids: got %0d,%0d expected 2,3", wb_trans_id[0], wb_trans_id[1]); end
    n_cmp++; if (wb_ex_valid !== 2'b10 || wb_ex_cause[1] !== 64'hBAD) begin n_err++; $display("FAIL all_c3_ex: got %b/%h expected 10/bad", wb_ex_valid, wb_ex_cause[1]); end
    step();
    n_cmp++; if (wb_valid !== 2'b00) begin n_err++; $display("FAIL all_c4_valid: got %b expected 00", wb_valid); end
    // rr_q back at 0: FLU must win port 0 over FPU
    drive(2'd0, 3'd4, 64'h200);
    drive(2'd3, 3'd6, 64'h203);
    step();
    idle();
    step();
    n_cmp++; if (wb_valid !== 2'b11 || wb_trans_id[0] !== 3'd4 || wb_trans_id[1] !== 3'd6) begin
      n_err++; $display("FAIL rr_wrap: got %b ids %0d,%0d expected 11 ids 4,6", wb_valid, wb_trans_id[0], wb_trans_id[1]);
    end
  endtask

  task automatic test_overflow();
    idle();
    flush = 1'b1;
    step();
    got_seq.delete();
    for (int c = 0; c < 22; c++) begin
      idle();
      if (c <= 8) drive(2'd0, 3'(c + 1), 64'hF000_0000_0000_0000 | 64'(c + 1));
      if (c == 0 || (c <= 8 && (c % 2) == 1)) drive(2'd1, 3'd0, 64'hA1);
      if (c <= 8 && (c % 2) == 0) begin
        drive(2'd2, 3'd0, 64'hA2);
        drive(2'd3, 3'd0, 64'hA3);
      end
      step();
      for (int p = 0; p < 2; p++) begin
        if (wb_valid[p] && wb_data[p][63:48] == 16'hF000) begin
          got_seq.push_back(wb_data[p][7:0]);
          n_cmp++; if (wb_trans_id[p] !== 3'(wb_data[p][7:0])) begin n_err++; $display("FAIL ovf_id_match: got %0d expected %0d", wb_trans_id[p], 3'(wb_data[p][7:0])); end
        end
      end
      if (c == 3) begin n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL stall_cnt2: got %b expected 0", issue_stall); end end
      if (c == 4) begin n_cmp++; if (issue_stall !== 1'b1) begin n_err++; $display("FAIL stall_cnt3: got %b expected 1", issue_stall); end end
      if (c == 7) begin n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_full_pushpop: got %b expected 0", overflow); end end
      if (c == 8) begin n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_drop: got %b expected 1", overflow); end end
    end
    n_cmp++; if (got_seq.size() !== 8) begin n_err++; $display("FAIL ovf_count: got %0d expected 8", got_seq.size()); end
    for (int i = 0; i < got_seq.size() && i < 8; i++) begin
      n_cmp++; if (got_seq[i] !== 8'(i + 1)) begin n_err++; $display("FAIL ovf_order[%0d]: got %0d expected %0d", i, got_seq[i], i + 1); end
    end
    n_cmp++; if (issue_stall !== 1'b0) begin n_err++; $display("FAIL stall_drained: got %b expected 0", issue_stall); end
    idle();
    flush = 1'b1;
    step();
    idle();
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_after_flush: got %b expected 1", overflow); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(2'd0, 3'd1, 64'h1);
    drive(2'd1, 3'd2, 64'h2);
    drive(2'd2, 3'd3, 64'h3);
    step();
    idle();
    flush = 1'b1;
    drive(2'd3, 3'd7, 64'h7);
    step();
    idle();
    for (int c = 0; c < 6; c++) begin
      n_cmp++; if (wb_valid !== 2'b00) begin n_err++; $display("FAIL flush_quiet[%0d]: got %b expected 00", c, wb_valid); end
      step();
    end
    n_cmp++; if (overflow !== 1'b0 || issue_stall !== 1'b0) begin n_err++; $display("FAIL flush_flags: got ovf %b stall %b expected 0/0", overflow, issue_stall); end
    drive(2'd0, 3'd4, 64'h44);
    step();
    idle();
    step();
    n_cmp++; if (wb_valid !== 2'b01 || wb_trans_id[0] !== 3'd4 || wb_data[0] !== 64'h44) begin
      n_err++; $display("FAIL flush_recover: got %b id %0d data %h expected 01 id 4 data 44", wb_valid, wb_trans_id[0], wb_data[0]);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    for (int s = 0; s < 4; s++) drive(2'(s), 3'(s), 64'h300 + 64'(s));
    step();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (wb_valid !== 2'b00) begin n_err++; $display("FAIL reset_mid[%0d]: got %b expected 00", c, wb_valid); end
      step();
    end
  endtask

  task automatic test_dup();
    logic dup_exp;
`ifdef EX_WB_DUP_CHECK_EN
    dup_exp = 1'b1;
`else
    dup_exp = 1'b0;
`endif
    do_reset();
    drive(2'd1, 3'd2, 64'h12);
    step();
    idle();
    drive(2'd3, 3'd3, 64'h33);
    step();
    idle();
    step();
    step();
    n_cmp++; if (dup_err !== 1'b0) begin n_err++; $display("FAIL dup_distinct: got %b expected 0", dup_err); end
    do_reset();
    drive(2'd1, 3'd2, 64'h12);
    step();
    idle();
    drive(2'd3, 3'd2, 64'h32);
    step();
    idle();
    n_cmp++; if (dup_err !== dup_exp) begin n_err++; $display("FAIL dup_queued: got %b expected %b", dup_err, dup_exp); end
    do_reset();
    drive(2'd0, 3'd5, 64'h50);
    drive(2'd1, 3'd5, 64'h51);
    step();
    idle();
    step();
    n_cmp++; if (dup_err !== 1'b0) begin n_err++; $display("FAIL dup_ports_early: got %b expected 0", dup_err); end
    step();
    n_cmp++; if (dup_err !== dup_exp) begin n_err++; $display("FAIL dup_ports: got %b expected %b", dup_err, dup_exp); end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_all_sources();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_dup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
